// File: rtl/des_round_seq.sv
// Control sequencer for an iterative single-round DES datapath: INIT, 16 Feistel
// rounds with per-round C/D rotation, FINAL capture, plus a one-deep request buffer.
module des_round_seq #(
  parameter logic [15:0] SINGLE_MASK = 16'h8103
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       decrypt,
  output logic       busy,
  output logic       init_sel,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       out_en,
  output logic       done,
  output logic       pending,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, INIT, ROUND, FINAL} state_t;

  state_t     state, state_nx;
  logic [3:0] idx, idx_nx;
  logic       mode, mode_nx;
  logic       pend, pend_nx;
  logic       pend_mode, pend_mode_nx;
  logic       ovr, ovr_nx;
  logic       done_r;

  // Decrypt walks the encrypt schedule backwards, shifted by one round:
  // round 0 uses no rotation, round j uses the encrypt amount of round 16-j.
  function automatic logic [1:0] shift_amt(input logic dec, input logic [3:0] r);
    logic [3:0] er;
    er = dec ? (4'd0 - r) : r;
    if (dec && (r == 4'd0)) return 2'd0;
    return SINGLE_MASK[er] ? 2'd1 : 2'd2;
  endfunction

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    mode_nx      = mode;
    pend_nx      = pend;
    pend_mode_nx = pend_mode;
    ovr_nx       = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          state_nx = INIT;
          mode_nx  = decrypt;
        end
      end
      INIT: begin
        state_nx = ROUND;
        idx_nx   = 4'd0;
      end
      ROUND: begin
        idx_nx = idx + 4'd1;
        if (idx == 4'd15) state_nx = FINAL;
      end
      FINAL: begin
        if (pend) begin
          // Buffered request issues now; a simultaneous load refills the buffer.
          state_nx = INIT;
          mode_nx  = pend_mode;
          pend_nx  = load;
          if (load) pend_mode_nx = decrypt;
        end else if (load) begin
          state_nx = INIT;
          mode_nx  = decrypt;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (load && ((state == INIT) || (state == ROUND))) begin
      if (!pend) begin
        pend_nx      = 1'b1;
        pend_mode_nx = decrypt;
      end else begin
        ovr_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 4'd0;
      mode      <= 1'b0;
      pend      <= 1'b0;
      pend_mode <= 1'b0;
      ovr       <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      mode      <= mode_nx;
      pend      <= pend_nx;
      pend_mode <= pend_mode_nx;
      ovr       <= ovr_nx;
      done_r    <= (state == FINAL);
    end
  end

  // Moore outputs: decoded from registered state only.
  assign busy      = (state != IDLE);
  assign init_sel  = (state == INIT);
  assign round_en  = (state == ROUND);
  assign round_idx = round_en ? idx : 4'd0;
  assign key_shift = round_en ? shift_amt(mode, idx) : 2'd0;
  assign key_dir   = round_en & mode;
  assign out_en    = (state == FINAL);
  assign done      = done_r;
  assign pending   = pend;
  assign overrun   = ovr;

endmodule

// File: tb/tb_des_round_seq.sv
// Bench for des_round_seq: directed scenario tables plus a random run against a
// timing-offset reference model with an explicit request queue.
module tb_des_round_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       decrypt = 1'b0;
  logic       busy, init_sel, round_en, key_dir, out_en, done, pending, overrun;
  logic [3:0] round_idx;
  logic [1:0] key_shift;

  des_round_seq dut (
    .clk(clk), .reset(reset), .load(load), .decrypt(decrypt),
    .busy(busy), .init_sel(init_sel), .round_en(round_en),
    .round_idx(round_idx), .key_shift(key_shift), .key_dir(key_dir),
    .out_en(out_en), .done(done), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int c = 0;
  logic [13:0] lg [0:79];

  // DES key schedule as published for encryption.
  int enc_sched [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Reference model: a block is described by the cycle of its INIT and its mode.
  bit m_active = 0;
  int m_start = 0;
  bit m_mode = 0;
  bit m_q [$];
  bit m_done = 0;
  bit m_ovr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, c);
  endtask

  function automatic logic [13:0] dut_vec();
    return {busy, init_sel, round_en, round_idx, key_shift, key_dir,
            out_en, done, pending, overrun};
  endfunction

  function automatic logic [13:0] exp_vec(input int t);
    int ph;
    logic [3:0] ri;
    logic [1:0] ks;
    bit ren;
    ph  = m_active ? (t - m_start) : -1;
    ren = (ph >= 1) && (ph <= 16);
    ri  = ren ? 4'(ph - 1) : 4'd0;
    if (!ren) ks = 2'd0;
    else if (!m_mode) ks = 2'(enc_sched[ph - 1]);
    else if (ph == 1) ks = 2'd0;
    else ks = 2'(enc_sched[16 - (ph - 1)]);
    return {m_active, ph == 0, ren, ri, ks, ren & m_mode,
            ph == 17, m_done, m_q.size() != 0, m_ovr};
  endfunction

  task automatic model_edge(input bit ld, input bit dc, input bit rs, input int t);
    int ph;
    ph = m_active ? (t - m_start) : -1;
    m_ovr  = 0;
    m_done = 0;
    if (rs) begin
      m_active = 0;
      m_mode = 0;
      m_q.delete();
    end else if (ph == 17) begin
      m_done = 1;
      if (m_q.size() != 0) begin
        m_start = t + 1;
        m_mode = m_q.pop_front();
        if (ld) m_q.push_back(dc);
      end else if (ld) begin
        m_start = t + 1;
        m_mode = dc;
      end else begin
        m_active = 0;
      end
    end else if (m_active) begin
      if (ld) begin
        if (m_q.size() == 0) m_q.push_back(dc);
        else m_ovr = 1;
      end
    end else if (ld) begin
      m_active = 1;
      m_start = t + 1;
      m_mode = dc;
    end
  endtask

  task automatic cycle(input bit ld, input bit dc, input bit rs);
    load = ld;
    decrypt = dc;
    reset = rs;
    @(posedge clk);
    model_edge(ld, dc, rs, c);
    c++;
    #1;
    chk("model", int'(dut_vec()), int'(exp_vec(c)));
  endtask

  task automatic run_scn(input int n, input int la, input bit da, input int lb, input bit db,
                         input int lc, input bit dc, input int rat);
    bit ld, d;
    cycle(0, 0, 1);
    c = 0;
    lg[0] = dut_vec();
    for (int i = 0; i < n; i++) begin
      ld = (i == la) || (i == lb) || (i == lc);
      d  = (i == la) ? da : (i == lb) ? db : (i == lc) ? dc : 1'b0;
      cycle(ld, d, i == rat);
      lg[c] = dut_vec();
    end
    load = 0;
    reset = 0;
  endtask

  function automatic int sig(input logic [13:0] v, input int s);
    case (s)
      0: return int'(v[13]);
      1: return int'(v[12]);
      2: return int'(v[11]);
      3: return int'(v[10:7]);
      4: return int'(v[6:5]);
      5: return int'(v[4]);
      6: return int'(v[3]);
      7: return int'(v[2]);
      8: return int'(v[1]);
      default: return int'(v[0]);
    endcase
  endfunction

  typedef struct {
    int scn;
    int cyc;
    int sg;
    int val;
  } vec_t;

  string sname [10] = '{"busy","init_sel","round_en","round_idx","key_shift",
                        "key_dir","out_en","done","pending","overrun"};

  vec_t tbl [$];

  task automatic apply_tbl(input int scn);
    foreach (tbl[k]) begin
      if (tbl[k].scn == scn)
        chk($sformatf("s%0d_c%0d_%s", scn, tbl[k].cyc, sname[tbl[k].sg]),
            sig(lg[tbl[k].cyc], tbl[k].sg), tbl[k].val);
    end
  endtask

  function automatic int sum_sig(input int s, input int a, input int b);
    int acc = 0;
    for (int i = a; i <= b; i++) acc += sig(lg[i], s);
    return acc;
  endfunction

  initial begin
    tbl = '{
      '{0, 0, 0, 0}, '{0, 0, 7, 0}, '{0, 1, 1, 1}, '{0, 1, 0, 1}, '{0, 2, 2, 1},
      '{0, 2, 3, 0}, '{0, 2, 4, 1}, '{0, 10, 4, 1}, '{0, 17, 3, 15}, '{0, 17, 4, 1},
      '{0, 5, 5, 0}, '{0, 18, 6, 1}, '{0, 18, 7, 0}, '{0, 19, 7, 1}, '{0, 19, 0, 0},
      '{0, 20, 7, 0},
      '{1, 2, 4, 0}, '{1, 2, 5, 1}, '{1, 3, 4, 1}, '{1, 17, 5, 1}, '{1, 18, 5, 0},
      '{2, 6, 8, 1}, '{2, 18, 8, 1}, '{2, 19, 8, 0}, '{2, 19, 1, 1}, '{2, 19, 7, 1},
      '{2, 21, 5, 1}, '{2, 37, 7, 1},
      '{3, 7, 9, 0}, '{3, 8, 9, 1}, '{3, 9, 9, 0},
      '{4, 36, 8, 1}, '{4, 37, 8, 0}, '{4, 37, 1, 1}, '{4, 55, 7, 1},
      '{5, 10, 0, 0}, '{5, 10, 8, 0}, '{5, 10, 3, 0}, '{5, 13, 1, 1}, '{5, 31, 7, 1}
    };

    // Single encrypt block.
    run_scn(24, 0, 0, -1, 0, -1, 0, -1);
    apply_tbl(0);
    chk("enc_shift_sum", sum_sig(4, 2, 17), 28);
    chk("enc_busy_cycles", sum_sig(0, 0, 24), 18);
    chk("enc_done_pulses", sum_sig(7, 0, 24), 1);

    // Single decrypt block.
    run_scn(24, 0, 1, -1, 0, -1, 0, -1);
    apply_tbl(1);
    chk("dec_shift_sum", sum_sig(4, 2, 17), 27);
    chk("dec_keydir_cycles", sum_sig(5, 0, 24), 16);

    // Buffered second request.
    run_scn(42, 0, 0, 5, 1, -1, 0, -1);
    apply_tbl(2);
    chk("buf_pending_cycles", sum_sig(8, 6, 18), 13);
    chk("buf_keydir_cycles", sum_sig(5, 19, 42), 16);
    chk("buf_overrun", sum_sig(9, 0, 42), 0);

    // Third request dropped.
    run_scn(42, 0, 0, 5, 1, 7, 0, -1);
    apply_tbl(3);
    chk("drop_done_pulses", sum_sig(7, 0, 42), 2);
    chk("drop_overrun_pulses", sum_sig(9, 0, 42), 1);

    // Load during FINAL with buffer full refills it.
    run_scn(58, 0, 0, 5, 1, 18, 0, -1);
    apply_tbl(4);
    chk("refill_pending_cycles", sum_sig(8, 6, 36), 31);
    chk("refill_overrun", sum_sig(9, 0, 58), 0);
    chk("refill_done_pulses", sum_sig(7, 0, 58), 3);

    // Reset mid-block, then restart.
    run_scn(34, 0, 0, 12, 0, -1, 0, 9);
    apply_tbl(5);
    chk("abort_state_vec", int'(lg[10]), 0);
    chk("abort_done_pulses", sum_sig(7, 10, 30), 0);
    chk("abort_outen_pulses", sum_sig(6, 10, 34), 1);

    // Random traffic against the model.
    cycle(0, 0, 1);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(3) == 0, 1'($urandom), $urandom_range(199) == 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/des_round_seq.md
Name: des_round_seq

Overview:
- Control sequencer for the iterative single-round DES datapath behind the lab top-level (64-bit data_in/key_in, load, 64-bit data_out).
- Accepts a load request and steps the datapath through its phases:
  - initial permutation / PC-1 load;
  - 16 Feistel rounds, with the correct C/D key rotation per round for encrypt or decrypt;
  - final permutation capture.
- Buffers one pending request so back-to-back blocks issue without gaps.
- Holds no 64-bit data; it drives datapath control only.

Parameters:
SINGLE_MASK, 16'h8103, bit i = 1 means encrypt round i (0-based) rotates by 1, else by 2 (DES schedule: rounds 0,1,8,15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load  input  1  start request; sampled every edge
decrypt  input  1  mode for the request: 0 encrypt, 1 decrypt; sampled with load
busy  output  1  high in INIT, ROUND, FINAL
init_sel  output  1  datapath loads IP(data_in), PC-1(key_in) this cycle
round_en  output  1  datapath executes one Feistel round this cycle
round_idx  output  4  current round 0..15; 0 outside ROUND
key_shift  output  2  C/D rotate amount applied this round (0, 1 or 2)
key_dir  output  1  rotate direction: 0 left (encrypt), 1 right (decrypt)
out_en  output  1  datapath captures FP(R16,L16) into data_out at end of this cycle
done  output  1  one-cycle pulse; data_out valid in this cycle
pending  output  1  one request buffered
overrun  output  1  one-cycle pulse; a request was dropped

Behaviour:
Reset:
- state=IDLE.
- round_idx=0, mode=0, pending=0.
- All outputs 0.
- Reset mid-operation aborts the block: no out_en, no done, pending cleared.

Outputs:
- All outputs are decoded from registered state (Moore).
- No combinational path from load/decrypt to any output.

State machine:
- IDLE:
  - load=1 at edge -> INIT; mode latched from decrypt.
- INIT (1 cycle):
  - init_sel=1 -> ROUND with round_idx=0.
- ROUND (16 cycles):
  - round_en=1, key_dir=mode.
  - round_idx increments each edge; at 15 -> FINAL.
- FINAL (1 cycle):
  - out_en=1.
  - Next request source, in priority order: pending buffer, else load input.
  - If a request is available -> INIT with that request's mode; else -> IDLE.
  - When pending is consumed and load=1 in the same cycle: new request enters the buffer, pending stays 1, no overrun.
- done: registered copy of out_en; high the cycle after FINAL.

Key shift rules:
- Encrypt, round i: key_shift = 1 if SINGLE_MASK[i] else 2.
- Decrypt:
  - round 0: key_shift = 0;
  - round j >= 1: key_shift = encrypt shift of round 16-j.
- Resulting sequences:
  - Encrypt: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28).
  - Decrypt: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 27).
- key_shift = 0 outside ROUND.

Pending buffer (depth 1):
- load=1 while busy (INIT/ROUND, or FINAL with pending already full) and pending=0 -> buffer {decrypt}, pending=1.
- load=1 while busy and pending=1 (except the FINAL consume case) -> request dropped; overrun=1 in the next cycle.
- Buffered mode is unaffected by later decrypt changes.

Latency and throughput:
- load sampled at edge ending cycle 0:
  - INIT in cycle 1;
  - ROUND in cycles 2-17;
  - FINAL in cycle 18;
  - done in cycle 19.
- Back-to-back throughput: 18 cycles per block; the next INIT is in the cycle right after FINAL.
- done of block N can coincide with INIT of block N+1.

Test Plan:
- Reset, load=1/decrypt=0 in cycle 0 -> required response:
  - init_sel cycle 1; round_en cycles 2-17 with round_idx 0..15;
  - key_shift 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, key_dir=0;
  - out_en cycle 18; done cycle 19 only; busy cycles 1-18.
- load=1/decrypt=1 in cycle 0 -> required response:
  - key_dir=1 cycles 2-17;
  - key_shift 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (bench checks sum 27).
- load cycle 0 (enc), load cycle 5 (dec) -> required response:
  - pending=1 cycles 6-18;
  - second INIT cycle 19 with key_dir=1 in its rounds;
  - done cycles 19 and 37; no overrun.
- load cycles 0, 5, 7 -> required response: overrun=1 cycle 8 only; exactly two done pulses (19, 37).
- load cycles 0, 5, 18 (FINAL, pending full) -> required response:
  - no overrun; pending remains 1 through cycle 36;
  - done at 19, 37, 55.
- load cycle 0, reset=1 in cycle 9 (round_idx=7) -> required response:
  - cycle 10: all outputs 0, state IDLE, no done;
  - load in cycle 12 -> done in cycle 31.
